reduction_binary_tree_8_1_seq: RTL

- Pipelined 8-to-1 binary reduction tree: registers eight lanes, sums them pairwise over log2(N) registered adder levels, and accumulates successive beats into one result per group delimited by i_last.
- Collection counterpart of the 1-to-N distribution tree. Sits at the output side of the NoC, gathering per-PE partial sums back to a single result port.

---
 rtl/reduction_binary_tree_8_1_seq_pkg.sv | 32 +++
 rtl/reduction_binary_tree_8_1_seq_adder_stage.sv | 53 +++++
 rtl/reduction_binary_tree_8_1_seq.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/reduction_binary_tree_8_1_seq_pkg.sv
// Shared constants and helpers for the 8-to-1 reduction tree and its adder levels.
package reduction_binary_tree_8_1_seq_pkg;

  // Default configuration of the collection tree.
  localparam int RBT_DATA_WIDTH     = 32;
  localparam int RBT_NUM_INPUT_DATA = 8;
  localparam int RBT_ACC_GUARD      = 8;

  // Number of registered adder levels for n lanes.
  function automatic int calc_num_level(input int n);
    return $clog2(n);
  endfunction

  // Result width: lane width, one growth bit per level, plus accumulator guard bits.
  function automatic int calc_out_width(input int dw, input int n, input int guard);
    return dw + $clog2(n) + guard;
  endfunction

  // Width of one lane after l adder levels.
  function automatic int LEVEL_WIDTH(input int dw, input int l);
    return dw + l;
  endfunction

  // Bit offset of lane k in a flat bus of w-bit lanes.
  function automatic int lane_lsb(input int k, input int w);
    return k * w;
  endfunction

  localparam int RBT_NUM_LEVEL = calc_num_level(RBT_NUM_INPUT_DATA);
  localparam int RBT_OUT_WIDTH = calc_out_width(RBT_DATA_WIDTH, RBT_NUM_INPUT_DATA, RBT_ACC_GUARD);

endpackage

// File: rtl/reduction_binary_tree_8_1_seq_adder_stage.sv
// One registered level of the reduction tree: adds adjacent lane pairs with one bit
// of growth and delays the beat valid/last flags alongside the sums.
module reduction_adder_stage
  import reduction_binary_tree_8_1_seq_pkg::*;
#(
  parameter int NUM_PAIRS = 4,
  parameter int IN_WIDTH  = 32,
  localparam int OUT_W    = IN_WIDTH + 1
) (
  input  logic                          CLK,
  input  logic                          rst,
  input  logic                          i_en,
  input  logic                          i_valid,
  input  logic                          i_last,
  input  logic [2*NUM_PAIRS*IN_WIDTH-1:0] i_data,
  output logic                          o_valid,
  output logic                          o_last,
  output logic [NUM_PAIRS*OUT_W-1:0]    o_data
);

  logic [NUM_PAIRS*OUT_W-1:0] w_sum;

  for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_pair
    logic signed [IN_WIDTH-1:0] w_a;
    logic signed [IN_WIDTH-1:0] w_b;
    assign w_a = i_data[lane_lsb(2*p, IN_WIDTH) +: IN_WIDTH];
    assign w_b = i_data[lane_lsb(2*p+1, IN_WIDTH) +: IN_WIDTH];
    // Operands are sign-extended by one bit so the pair sum cannot overflow.
    assign w_sum[lane_lsb(p, OUT_W) +: OUT_W] = OUT_W'(w_a) + OUT_W'(w_b);
  end

  logic [NUM_PAIRS*OUT_W-1:0] r_sum_p1;
  logic                       r_vld_p1;
  logic                       r_last_p1;

  // ---- level register: pair sums and beat flags, cleared on reset or disable ----
  always_ff @(posedge CLK) begin
    if (!rst || !i_en) begin
      r_sum_p1  <= '0;
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
    end else begin
      r_sum_p1  <= w_sum;
      r_vld_p1  <= i_valid;
      r_last_p1 <= i_last;
    end
  end

  assign o_data  = r_sum_p1;
  assign o_valid = r_vld_p1;
  assign o_last  = r_last_p1;

endmodule

// File: rtl/reduction_binary_tree_8_1_seq.sv
// Pipelined N-to-1 reduction tree: masks and registers the input lanes, sums them
// pairwise over log2(N) registered levels, then accumulates beats into one signed
// result per group delimited by i_last.
module reduction_binary_tree_8_1_seq
  import reduction_binary_tree_8_1_seq_pkg::*;
#(
  parameter int DATA_WIDTH      = RBT_DATA_WIDTH,
  parameter int NUM_INPUT_DATA  = RBT_NUM_INPUT_DATA,
  parameter int NUM_OUTPUT_DATA = 1,
  parameter int ACC_GUARD       = RBT_ACC_GUARD,
  localparam int NUM_LEVEL      = calc_num_level(NUM_INPUT_DATA),
  localparam int OUT_WIDTH      = calc_out_width(DATA_WIDTH, NUM_INPUT_DATA, ACC_GUARD)
) (
  input  logic                                 CLK,
  input  logic                                 rst,
  input  logic                                 i_en,
  input  logic [NUM_INPUT_DATA-1:0]            i_valid,
  input  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0] i_data_bus,
  input  logic                                 i_last,
  output logic                                 o_valid,
  output logic [OUT_WIDTH-1:0]                 o_data_bus,
  output logic                                 o_acc_active
);

  if (NUM_OUTPUT_DATA != 1) begin : g_chk_out
    $error("reduction_binary_tree_8_1_seq: NUM_OUTPUT_DATA must be 1");
  end
  if (NUM_INPUT_DATA < 2 || (NUM_INPUT_DATA & (NUM_INPUT_DATA - 1)) != 0) begin : g_chk_in
    $error("reduction_binary_tree_8_1_seq: NUM_INPUT_DATA must be a power of 2, at least 2");
  end

  // Accumulator addition; wraps modulo 2^OUT_WIDTH with no saturation.
  function automatic logic signed [OUT_WIDTH-1:0] acc_add(
    input logic signed [OUT_WIDTH-1:0] a,
    input logic signed [OUT_WIDTH-1:0] b
  );
    return a + b;
  endfunction

  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0] w_masked_p0;

  for (genvar k = 0; k < NUM_INPUT_DATA; k++) begin : g_mask
    assign w_masked_p0[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH] =
      i_valid[k] ? i_data_bus[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH] : '0;
  end

  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0] r_data_p0;
  logic                                 r_vld_p0;
  logic                                 r_last_p0;

  // ---- stage 0: masked input lanes; a beat with no valid lane is a bubble ----
  always_ff @(posedge CLK) begin
    if (!rst || !i_en) begin
      r_data_p0 <= '0;
      r_vld_p0  <= 1'b0;
      r_last_p0 <= 1'b0;
    end else begin
      r_data_p0 <= w_masked_p0;
      r_vld_p0  <= |i_valid;
      r_last_p0 <= i_last & (|i_valid);
    end
  end

  // ---- stages 1..NUM_LEVEL: registered pairwise adder levels ----
  for (genvar l = 1; l <= NUM_LEVEL; l++) begin : g_lvl
    localparam int IN_W  = LEVEL_WIDTH(DATA_WIDTH, l - 1);
    localparam int PAIRS = NUM_INPUT_DATA >> l;

    logic [2*PAIRS*IN_W-1:0]   w_in;
    logic                      w_in_vld;
    logic                      w_in_last;
    logic [PAIRS*(IN_W+1)-1:0] w_sum;
    logic                      w_vld;
    logic                      w_last;

    if (l == 1) begin : g_src
      assign w_in      = r_data_p0;
      assign w_in_vld  = r_vld_p0;
      assign w_in_last = r_last_p0;
    end else begin : g_src
      assign w_in      = g_lvl[l-1].w_sum;
      assign w_in_vld  = g_lvl[l-1].w_vld;
      assign w_in_last = g_lvl[l-1].w_last;
    end

    reduction_adder_stage #(
      .NUM_PAIRS (PAIRS),
      .IN_WIDTH  (IN_W)
    ) u_stage (
      .CLK     (CLK),
      .rst     (rst),
      .i_en    (i_en),
      .i_valid (w_in_vld),
      .i_last  (w_in_last),
      .i_data  (w_in),
      .o_valid (w_vld),
      .o_last  (w_last),
      .o_data  (w_sum)
    );
  end

  logic signed [DATA_WIDTH+NUM_LEVEL-1:0] w_tree_sum;
  logic signed [OUT_WIDTH-1:0]            w_sum_ext;
  logic                                   w_tree_vld;
  logic                                   w_tree_last;

  assign w_tree_sum  = g_lvl[NUM_LEVEL].w_sum;
  assign w_tree_vld  = g_lvl[NUM_LEVEL].w_vld;
  assign w_tree_last = g_lvl[NUM_LEVEL].w_last;
  assign w_sum_ext   = OUT_WIDTH'(w_tree_sum);

  logic signed [OUT_WIDTH-1:0] r_acc_po;
  logic signed [OUT_WIDTH-1:0] r_data_po;
  logic                        r_vld_po;
  logic                        r_active_po;

  // ---- output stage: accumulate beats, present the group sum on the last beat ----
  always_ff @(posedge CLK) begin
    if (!rst || !i_en) begin
      r_acc_po    <= '0;
      r_data_po   <= '0;
      r_vld_po    <= 1'b0;
      r_active_po <= 1'b0;
    end else begin
      r_vld_po <= w_tree_vld & w_tree_last;
      if (w_tree_vld) begin
        if (w_tree_last) begin
          r_data_po   <= acc_add(r_acc_po, w_sum_ext);
          r_acc_po    <= '0;
          r_active_po <= 1'b0;
        end else begin
          r_acc_po    <= acc_add(r_acc_po, w_sum_ext);
          r_active_po <= 1'b1;
        end
      end
    end
  end

  assign o_valid      = r_vld_po;
  assign o_data_bus   = r_data_po;
  assign o_acc_active = r_active_po;

endmodule
